sd_io_arbiter: RTL and testbench

- Shares the single host SD block-device channel between several block requesters: internal floppy, external floppy, SCSI disk.
- Each requester speaks the same level-handshake protocol the floppy track buffer uses (rd/wr held until busy seen, data streamed by sd_addr/data_en).
- Grants one whole sector transaction at a time, round-robin, and routes the data path to the granted requester only.
- Sits between the requesters and the HPS/SD glue.

---
 rtl/sd_io_arbiter.sv | 217 +++++++++++++++++++++
 tb/tb_sd_io_arbiter.sv | 367 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sd_io_arbiter.sv
// sd_io_arbiter
//   Shares the single host SD block-device channel between NUM_CLIENTS block
//   requesters (internal floppy, external floppy, SCSI disk). One whole sector
//   transaction is granted at a time, round-robin, and only the granted client
//   sees busy/done/data strobes. Write data is muxed from the granted client.
//
//   Optional build macro: ARB_TIMEOUT_EN
//     Adds a watchdog in ISSUE; if the host never raises hps_busy within
//     TIMEOUT cycles the request is dropped and cl_err pulses with cl_done.
//     Also adds the cl_err output port.
//
// Ports
//   clk, rst            clock, asynchronous active-low reset
//   cl_lba/cl_rd/cl_wr  per-client sector address and request levels
//   cl_dout             per-client write byte for the current sd_addr
//   cl_busy/cl_done     per-client busy level and completion pulse
//   cl_data_en          per-client read-data strobe (granted client only)
//   cl_err              per-client timeout pulse (ARB_TIMEOUT_EN only)
//   sd_addr/sd_data_in  broadcast byte index and read data from the host
//   hps_*               host-side request, handshake and data path

// Per-client slice of the data path: gates the read strobe and the write byte
// so only the granted client is visible.
module sd_io_arb_lane (
    input  logic       sel,
    input  logic       xfer,
    input  logic       hps_data_en,
    input  logic [7:0] din,
    output logic       data_en,
    output logic [7:0] dout
);
    assign data_en = sel & xfer & hps_data_en;
    assign dout    = sel ? din : 8'h00;
endmodule

module sd_io_arbiter #(
    parameter int          NUM_CLIENTS = 3,
    parameter int          LBA_W       = 32,
    parameter logic [23:0] TIMEOUT     = 24'd1000000
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_CLIENTS*LBA_W-1:0] cl_lba,
    input  logic [NUM_CLIENTS-1:0]       cl_rd,
    input  logic [NUM_CLIENTS-1:0]       cl_wr,
    input  logic [NUM_CLIENTS*8-1:0]     cl_dout,
    output logic [NUM_CLIENTS-1:0]       cl_busy,
    output logic [NUM_CLIENTS-1:0]       cl_done,
    output logic [NUM_CLIENTS-1:0]       cl_data_en,
`ifdef ARB_TIMEOUT_EN
    output logic [NUM_CLIENTS-1:0]       cl_err,
`endif
    output logic [8:0]                   sd_addr,
    output logic [7:0]                   sd_data_in,
    output logic [LBA_W-1:0]             hps_lba,
    output logic [1:0]                   hps_img,
    output logic                         hps_rd,
    output logic                         hps_wr,
    input  logic                         hps_busy,
    input  logic                         hps_data_en,
    input  logic [8:0]                   hps_addr,
    input  logic [7:0]                   hps_din,
    output logic [7:0]                   hps_dout
);
    localparam int GW = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, XFER, RELEASE} state_t;

    state_t                        state;
    logic [GW-1:0]                 grant;
    logic [GW-1:0]                 rr_ptr;
    logic [NUM_CLIENTS-1:0]        pend;
    logic [NUM_CLIENTS-1:0]        gsel;     // one-hot of registered grant
    logic [NUM_CLIENTS-1:0]        sel_oh;   // one-hot of candidate in IDLE
    logic [GW-1:0]                 sel_idx;
    logic                          sel_vld;
    logic [GW:0]                   rr_sum;
    logic [LBA_W-1:0]              sel_lba;
    logic                          sel_wr;
    logic [GW-1:0]                 grant_nxt;
    logic [NUM_CLIENTS-1:0][7:0]   lane_dout;

    assign pend       = cl_rd | cl_wr;
    assign sd_addr    = hps_addr;
    assign sd_data_in = hps_din;
    assign grant_nxt  = (grant == GW'(NUM_CLIENTS - 1)) ? '0 : grant + GW'(1);

    // Round-robin pick: walk offsets from the far end so the pending client
    // closest to rr_ptr is the one left in sel_idx.
    always_comb begin
        sel_idx = '0;
        sel_vld = 1'b0;
        rr_sum  = '0;
        for (int k = NUM_CLIENTS - 1; k >= 0; k--) begin
            rr_sum = {1'b0, rr_ptr} + (GW+1)'(k);
            if (rr_sum >= (GW+1)'(NUM_CLIENTS))
                rr_sum = rr_sum - (GW+1)'(NUM_CLIENTS);
            if (pend[rr_sum[GW-1:0]]) begin
                sel_idx = rr_sum[GW-1:0];
                sel_vld = 1'b1;
            end
        end
    end

    always_comb begin
        sel_lba = '0;
        sel_wr  = 1'b0;
        for (int i = 0; i < NUM_CLIENTS; i++) begin
            if (sel_oh[i]) begin
                sel_lba = cl_lba[i*LBA_W +: LBA_W];
                sel_wr  = cl_wr[i];
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CLIENTS; gi++) begin : g_lane
            assign gsel[gi]   = (grant == GW'(gi));
            assign sel_oh[gi] = (sel_idx == GW'(gi));
            sd_io_arb_lane u_lane (
                .sel         (gsel[gi]),
                .xfer        (state == XFER),
                .hps_data_en (hps_data_en),
                .din         (cl_dout[gi*8 +: 8]),
                .data_en     (cl_data_en[gi]),
                .dout        (lane_dout[gi])
            );
        end
    endgenerate

    // Non-granted lanes drive zero, so an OR is the write-data mux.
    always_comb begin
        hps_dout = 8'h00;
        for (int i = 0; i < NUM_CLIENTS; i++)
            hps_dout = hps_dout | lane_dout[i];
    end

`ifdef ARB_TIMEOUT_EN
    logic [23:0] tmo_cnt;
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            grant   <= '0;
            rr_ptr  <= '0;
            hps_rd  <= 1'b0;
            hps_wr  <= 1'b0;
            hps_lba <= '0;
            hps_img <= '0;
            cl_busy <= '0;
            cl_done <= '0;
`ifdef ARB_TIMEOUT_EN
            cl_err  <= '0;
            tmo_cnt <= '0;
`endif
        end else begin
            cl_done <= '0;
`ifdef ARB_TIMEOUT_EN
            cl_err  <= '0;
`endif
            case (state)
                IDLE: begin
                    // hps_busy here means someone else owns the channel.
                    if (sel_vld && !hps_busy) begin
                        grant   <= sel_idx;
                        hps_lba <= sel_lba;
                        hps_img <= 2'(sel_idx);
                        // Write wins over a simultaneous read; the read
                        // stays pending for a later grant.
                        hps_wr  <= sel_wr;
                        hps_rd  <= ~sel_wr;
                        cl_busy <= sel_oh;
`ifdef ARB_TIMEOUT_EN
                        tmo_cnt <= '0;
`endif
                        state   <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (hps_busy) begin
                        hps_rd <= 1'b0;
                        hps_wr <= 1'b0;
                        state  <= XFER;
                    end
`ifdef ARB_TIMEOUT_EN
                    else if (tmo_cnt == TIMEOUT - 24'd1) begin
                        hps_rd  <= 1'b0;
                        hps_wr  <= 1'b0;
                        cl_busy <= '0;
                        cl_done <= gsel;
                        cl_err  <= gsel;
                        rr_ptr  <= grant_nxt;
                        state   <= RELEASE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 24'd1;
                    end
`endif
                end
                XFER: begin
                    if (!hps_busy) begin
                        cl_busy <= '0;
                        cl_done <= gsel;
                        rr_ptr  <= grant_nxt;
                        state   <= RELEASE;
                    end
                end
                RELEASE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sd_io_arbiter.sv
module tb_sd_io_arbiter;
    logic        clk;
    logic        rst;
    logic [95:0] cl_lba;
    logic [2:0]  cl_rd, cl_wr;
    logic [23:0] cl_dout;
    logic [2:0]  cl_busy, cl_done, cl_data_en;
`ifdef ARB_TIMEOUT_EN
    logic [2:0]  cl_err;
`endif
    logic [8:0]  sd_addr;
    logic [7:0]  sd_data_in;
    logic [31:0] hps_lba;
    logic [1:0]  hps_img;
    logic        hps_rd, hps_wr;
    logic        hps_busy, hps_data_en;
    logic [8:0]  hps_addr;
    logic [7:0]  hps_din, hps_dout;

    int checks = 0;
    int errors = 0;

    sd_io_arbiter #(.NUM_CLIENTS(3), .LBA_W(32), .TIMEOUT(24'd16)) dut (
        .clk(clk), .rst(rst),
        .cl_lba(cl_lba), .cl_rd(cl_rd), .cl_wr(cl_wr), .cl_dout(cl_dout),
        .cl_busy(cl_busy), .cl_done(cl_done), .cl_data_en(cl_data_en),
`ifdef ARB_TIMEOUT_EN
        .cl_err(cl_err),
`endif
        .sd_addr(sd_addr), .sd_data_in(sd_data_in),
        .hps_lba(hps_lba), .hps_img(hps_img), .hps_rd(hps_rd), .hps_wr(hps_wr),
        .hps_busy(hps_busy), .hps_data_en(hps_data_en), .hps_addr(hps_addr),
        .hps_din(hps_din), .hps_dout(hps_dout)
    );

    // Each client drives a distinct write pattern derived from sd_addr.
    assign cl_dout = {sd_addr[7:0], sd_addr[7:0] ^ 8'h33, ~sd_addr[7:0]};

    function automatic logic [7:0] exp_dout(input logic [1:0] img, input logic [8:0] a);
        case (img)
            2'd0:    return ~a[7:0];
            2'd1:    return a[7:0] ^ 8'h33;
            default: return a[7:0];
        endcase
    endfunction

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
    endtask

    // Host results of the last served transaction
    logic [1:0]  h_img;
    logic        h_rd, h_wr, h_ok;
    logic [31:0] h_lba;
    int          h_den, h_oth, h_bad, h_bc;

    // Host model: wait for a request, raise busy after lat cycles, stream one
    // 512-byte sector, drop busy. Returns with the done edge just taken.
    task automatic host_serve(input int lat);
        logic [2:0] own;
        h_ok = 1'b0; h_den = 0; h_oth = 0; h_bad = 0; h_bc = 0;
        h_img = '0; h_rd = 1'b0; h_wr = 1'b0; h_lba = '0;
        for (int w = 0; w < 20 && !h_ok; w++) begin
            if (hps_rd | hps_wr) h_ok = 1'b1;
            else tick();
        end
        if (!h_ok) begin
            checks++; errors++;
            $display("FAIL host_wait: no hps_rd/hps_wr within 20 cycles, required a request");
            return;
        end
        h_img = hps_img; h_rd = hps_rd; h_wr = hps_wr; h_lba = hps_lba;
        own = 3'b001 << h_img;
        repeat (lat) tick();
        hps_busy = 1'b1;
        tick();
        for (int a = 0; a < 512; a++) begin
            hps_addr    = a[8:0];
            hps_din     = a[7:0] ^ 8'hA5;
            hps_data_en = 1'b1;
            #1;
            if ((cl_data_en & own) != 3'b000) h_den++;
            if ((cl_data_en & ~own) != 3'b000) h_oth++;
            if (h_wr && hps_dout !== exp_dout(h_img, a[8:0])) h_bad++;
            if (sd_addr !== a[8:0] || sd_data_in !== (a[7:0] ^ 8'hA5)) h_bc++;
            tick();
        end
        hps_data_en = 1'b0;
        hps_busy    = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        #3 rst = 1'b0;
        #1;
        checks++;
        if ({cl_busy, cl_done, cl_data_en, hps_rd, hps_wr} !== 11'b0) begin
            errors++;
            $display("FAIL reset_ctl: got %b required 0", {cl_busy, cl_done, cl_data_en, hps_rd, hps_wr});
        end
        checks++;
        if (hps_lba !== 32'h0 || hps_img !== 2'd0) begin
            errors++;
            $display("FAIL reset_lba: got lba %h img %0d required 0/0", hps_lba, hps_img);
        end
        tick();
        tick();
        rst = 1'b1;
        tick();
    endtask

    task automatic test_single_read();
        cl_rd = 3'b010;
        #1;
        checks++;
        if (hps_rd !== 1'b0) begin
            errors++; $display("FAIL sr_latency: hps_rd %b before edge, required 0", hps_rd);
        end
        tick();
        checks++;
        if (hps_rd !== 1'b1 || cl_busy !== 3'b010) begin
            errors++; $display("FAIL sr_grant: hps_rd %b cl_busy %b, required 1/010", hps_rd, cl_busy);
        end
        host_serve(3);
        checks++;
        if (h_img !== 2'd1 || h_lba !== 32'h1234 || h_rd !== 1'b1) begin
            errors++; $display("FAIL sr_req: img %0d lba %h rd %b, required 1/1234/1", h_img, h_lba, h_rd);
        end
        checks++;
        if (h_den != 512) begin
            errors++; $display("FAIL sr_data_en: got %0d strobes required 512", h_den);
        end
        checks++;
        if (h_oth != 0) begin
            errors++; $display("FAIL sr_other_en: got %0d foreign strobes required 0", h_oth);
        end
        checks++;
        if (h_bc != 0) begin
            errors++; $display("FAIL sr_bcast: got %0d sd_addr/sd_data_in errors required 0", h_bc);
        end
        checks++;
        if (cl_done !== 3'b010 || cl_busy !== 3'b000) begin
            errors++; $display("FAIL sr_done: cl_done %b cl_busy %b, required 010/000", cl_done, cl_busy);
        end
        cl_rd = 3'b000;
        tick();
        checks++;
        if (cl_done !== 3'b000) begin
            errors++; $display("FAIL sr_done_pulse: cl_done %b one cycle later, required 000", cl_done);
        end
        tick();
    endtask

    task automatic test_busy_block();
        hps_busy = 1'b1;
        cl_rd = 3'b001;
        repeat (3) tick();
        checks++;
        if (hps_rd !== 1'b0 || cl_busy !== 3'b000) begin
            errors++; $display("FAIL bb_block: hps_rd %b cl_busy %b, required 0/000", hps_rd, cl_busy);
        end
        hps_busy = 1'b0;
        tick();
        checks++;
        if (hps_rd !== 1'b1 || hps_img !== 2'd0) begin
            errors++; $display("FAIL bb_grant: hps_rd %b img %0d, required 1/0", hps_rd, hps_img);
        end
        host_serve(1);
        cl_rd = 3'b000;
        tick();
        tick();
    endtask

    task automatic test_round_robin();
        int dc [3];
        do_reset();
        dc[0] = 0; dc[1] = 0; dc[2] = 0;
        cl_rd = 3'b111;
        for (int k = 0; k < 6; k++) begin
            host_serve(1);
            checks++;
            if (h_img !== 2'(k % 3)) begin
                errors++; $display("FAIL rr_order: txn %0d got img %0d required %0d", k, h_img, k % 3);
            end
            for (int i = 0; i < 3; i++) if (cl_done[i]) dc[i]++;
            if (k == 5) cl_rd = 3'b000;
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (dc[i] != 2) begin
                errors++; $display("FAIL rr_done_cnt: client %0d got %0d pulses required 2", i, dc[i]);
            end
        end
        tick();
        tick();
    endtask

    task automatic test_write();
        cl_wr = 3'b100;
        host_serve(2);
        checks++;
        if (h_wr !== 1'b1 || h_rd !== 1'b0) begin
            errors++; $display("FAIL wr_op: hps_wr %b hps_rd %b, required 1/0", h_wr, h_rd);
        end
        checks++;
        if (h_img !== 2'd2 || h_lba !== 32'h00C0FFEE) begin
            errors++; $display("FAIL wr_req: img %0d lba %h, required 2/00c0ffee", h_img, h_lba);
        end
        checks++;
        if (h_bad != 0) begin
            errors++; $display("FAIL wr_dout: got %0d bad bytes required 0", h_bad);
        end
        checks++;
        if (cl_done !== 3'b100) begin
            errors++; $display("FAIL wr_done: cl_done %b required 100", cl_done);
        end
        cl_wr = 3'b000;
        tick();
        tick();
    endtask

    task automatic test_rd_wr();
        cl_rd = 3'b001;
        cl_wr = 3'b001;
        host_serve(1);
        checks++;
        if (h_wr !== 1'b1 || h_rd !== 1'b0 || h_img !== 2'd0) begin
            errors++; $display("FAIL rw_first: wr %b rd %b img %0d, required 1/0/0", h_wr, h_rd, h_img);
        end
        checks++;
        if (h_bad != 0) begin
            errors++; $display("FAIL rw_dout: got %0d bad bytes required 0", h_bad);
        end
        cl_wr = 3'b000;
        host_serve(1);
        checks++;
        if (h_rd !== 1'b1 || h_wr !== 1'b0 || h_img !== 2'd0) begin
            errors++; $display("FAIL rw_second: rd %b wr %b img %0d, required 1/0/0", h_rd, h_wr, h_img);
        end
        cl_rd = 3'b000;
        tick();
        tick();
    endtask

    task automatic test_reset_mid();
        // rr_ptr is 1 here, so client 2 wins over client 0 first.
        cl_rd = 3'b101;
        tick();
        checks++;
        if (hps_rd !== 1'b1 || hps_img !== 2'd2) begin
            errors++; $display("FAIL rm_first: hps_rd %b img %0d, required 1/2", hps_rd, hps_img);
        end
        hps_busy = 1'b1;
        tick();
        for (int a = 0; a < 100; a++) begin
            hps_addr = a[8:0]; hps_data_en = 1'b1;
            tick();
        end
        hps_addr = 9'd100;
        #1;
        checks++;
        if (cl_data_en !== 3'b100) begin
            errors++; $display("FAIL rm_xfer: cl_data_en %b before reset, required 100", cl_data_en);
        end
        rst = 1'b0;
        #1;
        checks++;
        if ({cl_busy, cl_done, cl_data_en, hps_rd, hps_wr} !== 11'b0 || hps_lba !== 32'h0 || hps_img !== 2'd0) begin
            errors++;
            $display("FAIL rm_async: ctl %b lba %h img %0d, required 0", {cl_busy, cl_done, cl_data_en, hps_rd, hps_wr}, hps_lba, hps_img);
        end
        hps_data_en = 1'b0;
        hps_busy = 1'b0;
        tick();
        tick();
        checks++;
        if (cl_done !== 3'b000) begin
            errors++; $display("FAIL rm_no_done: cl_done %b during reset, required 000", cl_done);
        end
        rst = 1'b1;
        tick();
        checks++;
        if (hps_rd !== 1'b1 || hps_img !== 2'd0 || hps_lba !== 32'hDEAD0000) begin
            errors++; $display("FAIL rm_restart: rd %b img %0d lba %h, required 1/0/dead0000", hps_rd, hps_img, hps_lba);
        end
        host_serve(1);
        cl_rd = 3'b100;
        host_serve(1);
        checks++;
        if (h_img !== 2'd2 || cl_done !== 3'b100) begin
            errors++; $display("FAIL rm_retry: img %0d done %b, required 2/100", h_img, cl_done);
        end
        cl_rd = 3'b000;
        tick();
        tick();
    endtask

`ifdef ARB_TIMEOUT_EN
    task automatic test_timeout();
        do_reset();
        cl_rd = 3'b011;
        tick();
        checks++;
        if (hps_rd !== 1'b1 || hps_img !== 2'd0) begin
            errors++; $display("FAIL to_grant: rd %b img %0d, required 1/0", hps_rd, hps_img);
        end
        repeat (15) tick();
        checks++;
        if (hps_rd !== 1'b1 || cl_err !== 3'b000) begin
            errors++; $display("FAIL to_early: rd %b err %b after 15 cycles, required 1/000", hps_rd, cl_err);
        end
        tick();
        checks++;
        if (hps_rd !== 1'b0 || cl_err !== 3'b001 || cl_done !== 3'b001) begin
            errors++; $display("FAIL to_abort: rd %b err %b done %b, required 0/001/001", hps_rd, cl_err, cl_done);
        end
        cl_rd = 3'b010;
        tick();
        tick();
        checks++;
        if (hps_rd !== 1'b1 || hps_img !== 2'd1) begin
            errors++; $display("FAIL to_next: rd %b img %0d, required 1/1", hps_rd, hps_img);
        end
        host_serve(1);
        cl_rd = 3'b000;
        tick();
        tick();
    endtask
`endif

    initial begin
        rst = 1'b1;
        cl_rd = '0; cl_wr = '0;
        cl_lba = {32'h00C0FFEE, 32'h00001234, 32'hDEAD0000};
        hps_busy = 1'b0; hps_data_en = 1'b0; hps_addr = '0; hps_din = '0;
        test_reset();
        test_single_read();
        test_busy_block();
        test_round_robin();
        test_write();
        test_rd_wr();
        test_reset_mid();
`ifdef ARB_TIMEOUT_EN
        test_timeout();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
